matrix_result_reader: RTL
=========================

MATRIX_RESULT_READER -- requirements
Module: matrix_result_reader

Interface
REQ-001 Parameter ENTRIES, default 9, SHALL set the number of result entries streamed per matrix.
REQ-002 Parameter DATA_W, default 16, SHALL set the result-entry width in bits.
REQ-003 Parameter ADDR_W, default 4, SHALL set the width of rd_addr; ADDR_W SHALL satisfy 2^ADDR_W >= ENTRIES.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-006 done  input  1  SHALL be the level "result stored" flag from the multiply controller.
REQ-007 rd_data  input  DATA_W  SHALL be the result-store read data, valid exactly one cycle after rd_en.
REQ-008 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-009 rd_en  output  1  SHALL be the result-store read strobe.
REQ-010 rd_addr  output  ADDR_W  SHALL be the result-store read address.
REQ-011 out_data  output  DATA_W  SHALL be the entry offered downstream.
REQ-012 out_valid  output  1  SHALL flag that out_data is valid.
REQ-013 out_last  output  1  SHALL flag the final entry (index ENTRIES-1).
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 States SHALL be IDLE, FETCH, WAIT, PRESENT and DRAIN.
- IDLE: the block SHALL arm on a rising edge of done (done=1, registered done_q=0) and go to FETCH with index=0.
- FETCH: the block SHALL assert rd_en for one cycle with rd_addr=index, then go to WAIT.
- WAIT: the block SHALL capture rd_data into out_data, set out_valid=1, and go to PRESENT.
- PRESENT: out_valid SHALL hold and out_data SHALL stay stable until out_valid&&out_ready.
  - On that handshake with index<ENTRIES-1: index+1, out_valid=0, go to FETCH.
  - On that handshake with index==ENTRIES-1: out_valid=0, go to DRAIN.
- DRAIN: the block SHALL stay until done==0, then return to IDLE.
REQ-016 Latency SHALL be 3 cycles from the done rising edge to the first out_valid, and 3 cycles minimum per entry with out_ready held high.
REQ-017 out_last SHALL equal out_valid && index==ENTRIES-1.
REQ-018 The index counter SHALL be ADDR_W bits wide, SHALL never exceed ENTRIES-1, and SHALL reset to 0 in IDLE.
REQ-019 A level-high done present on exit from reset SHALL NOT trigger a stream; only a 0->1 transition arms the block.
REQ-020 done changes while busy SHALL be ignored; a done that falls and rises again mid-stream SHALL NOT restart or extend the stream.
REQ-021 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-022 rd_en SHALL never be asserted outside FETCH.
REQ-023 The block SHALL issue exactly one read per entry.

Reset
REQ-024 When reset==0 at a rising clock edge, the block SHALL enter IDLE regardless of the current state, including mid-stream.
REQ-025 On that reset edge, the block SHALL clear:
- rd_en, out_valid, out_last, busy and done_q to 0;
- index and rd_addr to 0;
- out_data to 0.
REQ-026 The first done rising edge after reset deasserts SHALL start a fresh stream from index 0.

Structure
REQ-027 The state encoding, ENTRIES and DATA_W defaults SHALL live in a shared package used by both the multiply controller and this block.
REQ-028 The done edge detector SHALL be a sub-module named rise_detect, reusable by the controller for start.

Verification
REQ-029 Stream with no backpressure: result store preloaded with values 1..9, out_ready=1, done pulsed high -> 9 beats carry 1..9, out_last only on value 9, first out_valid 3 cycles after the done edge.
REQ-030 Backpressure: out_ready=0 for 5 cycles on entry 4 -> out_valid stays high and out_data stays at 4 throughout, with no extra rd_en.
REQ-031 Held done: done stays high for 40 cycles -> exactly one 9-beat stream, the block waits in DRAIN, and returns to IDLE one cycle after done falls.
REQ-032 Mid-stream reset: reset=0 during entry 5 -> next cycle busy=0, out_valid=0, index=0; the next done edge streams from entry 1.
REQ-033 Reset with done high: done=1 while reset deasserts -> no rd_en until done goes 0 then 1.
REQ-034 Done glitch: done toggles 1->0->1 during entry 2 -> the stream continues unchanged and ends after 9 beats.

Source files
------------

// File: rtl/matrix_result_reader_pkg.sv
// Shared definitions for the matrix multiply result path: streaming state
// encoding and default geometry, common to the controller and result reader.
package matrix_result_reader_pkg;

    localparam int DEF_ENTRIES = 9;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/matrix_result_reader_if.sv
// Bundle of the result-reader signals: done flag, result-store read port,
// downstream valid/ready stream and busy status.
interface matrix_result_reader_if
    import matrix_result_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              out_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;

    // master is the reader itself; slave is the controller/store/sink side
    modport master (
        input  done, rd_data, out_ready,
        output rd_en, rd_addr, out_data, out_valid, out_last, busy
    );

    modport slave (
        output done, rd_data, out_ready,
        input  rd_en, rd_addr, out_data, out_valid, out_last, busy
    );

endinterface

// File: rtl/rise_detect.sv
// Single-cycle 0->1 edge detector. A level already high when reset releases
// is not reported; the input must be seen low before an edge can fire.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q_reg;
    logic armed_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            level_q_reg <= 1'b0;
            armed_reg   <= ~level;
        end else begin
            level_q_reg <= level;
            if (!level) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rise = level & ~level_q_reg & armed_reg;

endmodule

// File: rtl/matrix_result_reader.sv
// Streams ENTRIES result words out of the result store after each done
// rising edge, one registered read per entry, over a valid/ready handshake.
module matrix_result_reader
    import matrix_result_reader_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    matrix_result_reader_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              done_rise;

    rise_detect u_done_rise (
        .clock (clock),
        .reset (reset),
        .level (bus.done),
        .rise  (done_rise)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            index_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // done edges are only consumed in IDLE, so toggles mid-stream are inert
    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            ST_IDLE: begin
                index_next     = '0;
                out_valid_next = 1'b0;
                if (done_rise) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                out_data_next  = bus.rd_data;
                out_valid_next = 1'b1;
                state_next     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_valid_reg && bus.out_ready) begin
                    out_valid_next = 1'b0;
                    if (index_reg == LAST_IDX) begin
                        state_next = ST_DRAIN;
                    end else begin
                        index_next = index_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_en     = (state_reg == ST_FETCH);
    assign bus.rd_addr   = index_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_valid_reg && (index_reg == LAST_IDX);
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule
